// File: rtl/fractal_pixel_engine.sv
// rtl/fractal_pixel_engine.sv - escape-time fractal raster source with valid/ready pixel output
module fractal_pixel_engine #(
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ITER_W    = 8
) (
    input  logic              out_stream_aclk,
    input  logic              periph_reset,
    input  logic              enable,
    input  logic              julia_mode,
    input  logic [ITER_W-1:0] max_iter,
    input  logic [DATA_W-1:0] origin_re,
    input  logic [DATA_W-1:0] origin_im,
    input  logic [DATA_W-1:0] step_re,
    input  logic [DATA_W-1:0] step_im,
    input  logic [DATA_W-1:0] julia_re,
    input  logic [DATA_W-1:0] julia_im,
    input  logic [7:0]        g_mul,
    input  logic [7:0]        b_mul,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              valid,
    input  logic              ready,
    output logic              sof,
    output logic              eol
);
    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int PW = 2 * DATA_W;
    localparam logic signed [PW-1:0] ESC_LIM = PW'(64'd4 << FRAC_BITS);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ITER, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [DATA_W-1:0]   zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic [DATA_W-1:0]   cur_re_q, cur_re_d, cur_im_q, cur_im_d;
    logic                mode_q, mode_d;
    logic [ITER_W-1:0]   max_iter_q, max_iter_d;
    logic [DATA_W-1:0]   org_re_q, org_re_d, org_im_q, org_im_d;
    logic [DATA_W-1:0]   stp_re_q, stp_re_d, stp_im_q, stp_im_d;
    logic [DATA_W-1:0]   jre_q, jre_d, jim_q, jim_d;
    logic [7:0]          gmul_q, gmul_d, bmul_q, bmul_d;
    logic [7:0]          r_q, r_d, g_q, g_d, b_q, b_d;
    logic                valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;

    logic signed [PW-1:0] zr_ext, zi_ext, cr_ext, ci_ext, zr2, zi2, zri2;
    logic                 escape, at_limit, in_set, last_x, last_y;
    logic [ITER_W-1:0]    iter_inc, count_w;
    logic [7:0]           cnt8, g_col, b_col;

    assign zr_ext = {{DATA_W{zr_q[DATA_W-1]}}, zr_q};
    assign zi_ext = {{DATA_W{zi_q[DATA_W-1]}}, zi_q};
    assign cr_ext = {{DATA_W{cr_q[DATA_W-1]}}, cr_q};
    assign ci_ext = {{DATA_W{ci_q[DATA_W-1]}}, ci_q};
    assign zr2    = (zr_ext * zr_ext) >>> FRAC_BITS;
    assign zi2    = (zi_ext * zi_ext) >>> FRAC_BITS;
    assign zri2   = ((zr_ext * zi_ext) <<< 1) >>> FRAC_BITS;

    assign escape   = (zr2 + zi2) > ESC_LIM;
    assign iter_inc = iter_q + ITER_W'(1);
    assign at_limit = (iter_inc == max_iter_q);
    assign count_w  = escape ? iter_q : max_iter_q;
    assign in_set   = (count_w == max_iter_q);
    // Only the low 8 bits of count*mul are kept, so an 8-bit product suffices.
    assign cnt8     = 8'(count_w);
    assign g_col    = cnt8 * gmul_q;
    assign b_col    = cnt8 * bmul_q;
    assign last_x   = (x_q == XW'(X_SIZE - 1));
    assign last_y   = (y_q == YW'(Y_SIZE - 1));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        iter_d     = iter_q;
        zr_d       = zr_q;
        zi_d       = zi_q;
        cr_d       = cr_q;
        ci_d       = ci_q;
        cur_re_d   = cur_re_q;
        cur_im_d   = cur_im_q;
        mode_d     = mode_q;
        max_iter_d = max_iter_q;
        org_re_d   = org_re_q;
        org_im_d   = org_im_q;
        stp_re_d   = stp_re_q;
        stp_im_d   = stp_im_q;
        jre_d      = jre_q;
        jim_d      = jim_q;
        gmul_d     = gmul_q;
        bmul_d     = bmul_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        valid_d    = valid_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    mode_d     = julia_mode;
                    max_iter_d = max_iter;
                    org_re_d   = origin_re;
                    org_im_d   = origin_im;
                    stp_re_d   = step_re;
                    stp_im_d   = step_im;
                    jre_d      = julia_re;
                    jim_d      = julia_im;
                    gmul_d     = g_mul;
                    bmul_d     = b_mul;
                    x_d        = '0;
                    y_d        = '0;
                    cur_re_d   = origin_re;
                    cur_im_d   = origin_im;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                if (mode_q) begin
                    zr_d = cur_re_q;
                    zi_d = cur_im_q;
                    cr_d = jre_q;
                    ci_d = jim_q;
                end else begin
                    zr_d = '0;
                    zi_d = '0;
                    cr_d = cur_re_q;
                    ci_d = cur_im_q;
                end
                iter_d  = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (escape || at_limit) begin
                    r_d     = in_set ? 8'd0 : cnt8;
                    g_d     = in_set ? 8'd0 : g_col;
                    b_d     = in_set ? 8'd0 : b_col;
                    sof_d   = (x_q == '0) && (y_q == '0);
                    eol_d   = last_x;
                    valid_d = 1'b1;
                    state_d = S_OUT;
                end else begin
                    zr_d   = DATA_W'(zr2 - zi2 + cr_ext);
                    zi_d   = DATA_W'(zri2 + ci_ext);
                    iter_d = iter_inc;
                end
            end
            S_OUT: begin
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = S_INIT;
                    if (last_x) begin
                        x_d      = '0;
                        cur_re_d = org_re_q;
                        cur_im_d = cur_im_q + stp_im_q;
                        if (last_y) begin
                            y_d     = '0;
                            state_d = S_IDLE;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d      = x_q + XW'(1);
                        cur_re_d = cur_re_q + stp_re_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            iter_q     <= '0;
            zr_q       <= '0;
            zi_q       <= '0;
            cr_q       <= '0;
            ci_q       <= '0;
            cur_re_q   <= '0;
            cur_im_q   <= '0;
            mode_q     <= 1'b0;
            max_iter_q <= '0;
            org_re_q   <= '0;
            org_im_q   <= '0;
            stp_re_q   <= '0;
            stp_im_q   <= '0;
            jre_q      <= '0;
            jim_q      <= '0;
            gmul_q     <= '0;
            bmul_q     <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            iter_q     <= iter_d;
            zr_q       <= zr_d;
            zi_q       <= zi_d;
            cr_q       <= cr_d;
            ci_q       <= ci_d;
            cur_re_q   <= cur_re_d;
            cur_im_q   <= cur_im_d;
            mode_q     <= mode_d;
            max_iter_q <= max_iter_d;
            org_re_q   <= org_re_d;
            org_im_q   <= org_im_d;
            stp_re_q   <= stp_re_d;
            stp_im_q   <= stp_im_d;
            jre_q      <= jre_d;
            jim_q      <= jim_d;
            gmul_q     <= gmul_d;
            bmul_q     <= bmul_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
        end
    end

    assign r     = r_q;
    assign g     = g_q;
    assign b     = b_q;
    assign valid = valid_q;
    assign sof   = sof_q;
    assign eol   = eol_q;
endmodule

// File: tb/tb_fractal_pixel_engine.sv
// tb/tb_fractal_pixel_engine.sv - scoreboard bench for fractal_pixel_engine on a 4x3 raster
module tb_fractal_pixel_engine;
    localparam int XS = 4;
    localparam int YS = 3;
    localparam int DW = 16;
    localparam int FB = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable, julia_mode, ready;
    logic [IW-1:0] max_iter;
    logic [DW-1:0] origin_re, origin_im, step_re, step_im, julia_re, julia_im;
    logic [7:0]    g_mul, b_mul, r, g, b;
    logic          valid, sof, eol;

    fractal_pixel_engine #(
        .X_SIZE(XS), .Y_SIZE(YS), .DATA_W(DW), .FRAC_BITS(FB), .ITER_W(IW)
    ) dut (
        .out_stream_aclk(clk), .periph_reset(rst), .enable(enable),
        .julia_mode(julia_mode), .max_iter(max_iter),
        .origin_re(origin_re), .origin_im(origin_im),
        .step_re(step_re), .step_im(step_im),
        .julia_re(julia_re), .julia_im(julia_im),
        .g_mul(g_mul), .b_mul(b_mul), .r(r), .g(g), .b(b),
        .valid(valid), .ready(ready), .sof(sof), .eol(eol)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       sof;
        logic       eol;
    } pix_t;

    pix_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   hs_cnt = 0;
    int   bp_mode = 0;
    pix_t mon_p, exp_p, prev_p;
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [DW-1:0] v);
        logic signed [DW-1:0] s;
        s = v;
        return longint'(s);
    endfunction

    function automatic int esc_count(input logic [DW-1:0] zr0, input logic [DW-1:0] zi0,
                                     input logic [DW-1:0] cr0, input logic [DW-1:0] ci0,
                                     input int mi);
        longint zr, zi, cr, ci, zr2, zi2, nzr;
        zr = sx(zr0); zi = sx(zi0); cr = sx(cr0); ci = sx(ci0);
        for (int it = 0; it < mi; it++) begin
            zr2 = (zr * zr) >>> FB;
            zi2 = (zi * zi) >>> FB;
            if (zr2 + zi2 > (longint'(4) << FB)) return it;
            if (it + 1 == mi) return mi;
            nzr = sx(DW'(zr2 - zi2 + cr));
            zi  = sx(DW'(((2 * zr * zi) >>> FB) + ci));
            zr  = nzr;
        end
        return mi;
    endfunction

    // Expected pixels for one frame, derived from the configuration the bench is driving.
    task automatic push_frame();
        logic [DW-1:0] cre, cim;
        int            cnt;
        pix_t          p;
        cim = origin_im;
        for (int y = 0; y < YS; y++) begin
            cre = origin_re;
            for (int x = 0; x < XS; x++) begin
                cnt = julia_mode ? esc_count(cre, cim, julia_re, julia_im, int'(max_iter))
                                 : esc_count('0, '0, cre, cim, int'(max_iter));
                p.r   = (cnt == int'(max_iter)) ? 8'd0 : 8'(cnt);
                p.g   = (cnt == int'(max_iter)) ? 8'd0 : 8'(cnt * int'(g_mul));
                p.b   = (cnt == int'(max_iter)) ? 8'd0 : 8'(cnt * int'(b_mul));
                p.sof = (x == 0) && (y == 0);
                p.eol = (x == XS - 1);
                sb.push_back(p);
                cre = cre + step_re;
            end
            cim = cim + step_im;
        end
    endtask

    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            mon_p = {r, g, b, sof, eol};
            if (prev_v && !prev_r) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_pixel", 32'(mon_p), 32'(prev_p));
            end
            if (valid && ready) begin
                hs_cnt++;
                check("sb_avail", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_p = sb.pop_front();
                    check("pixel", 32'(mon_p), 32'(exp_p));
                end
            end
            prev_v = valid;
            prev_r = ready;
            prev_p = mon_p;
        end
    end

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_idle_valid"}, 32'(valid), 32'd0);
    endtask

    task automatic wait_hs(input string tag, input int target);
        int n = 0;
        while (hs_cnt < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_reached"}, 32'(hs_cnt >= target), 32'd1);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!valid && n < 200) begin
            @(posedge clk);
            n++;
            #1;
        end
        check({tag, "_valid_seen"}, 32'(valid), 32'd1);
    endtask

    task automatic run_single(input string tag, input logic jm, input logic [IW-1:0] mi,
                              input logic [DW-1:0] ore, input int exp_lat,
                              input logic [23:0] exp_rgb);
        int n;
        julia_mode = jm; max_iter = mi; origin_re = ore; origin_im = '0;
        step_re = '0; step_im = '0; julia_re = '0; julia_im = '0;
        g_mul = 8'd3; b_mul = 8'd5;
        @(posedge clk);
        #1;
        push_frame();
        enable = 1'b1;
        wait_valid(tag, n);
        enable = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_rgb"}, 32'({r, g, b}), 32'(exp_rgb));
        check({tag, "_sof"}, 32'(sof), 32'd1);
        wait_drain(tag);
    endtask

    initial begin
        int base, n;
        enable = 1'b0; julia_mode = 1'b0; max_iter = 8'd16;
        origin_re = '0; origin_im = '0; step_re = '0; step_im = '0;
        julia_re = '0; julia_im = '0; g_mul = 8'd3; b_mul = 8'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_flags", 32'({sof, eol}), 32'd0);
        rst = 1'b0;

        run_single("mandel_esc", 1'b0, 8'd16, 16'h0200, 5, {8'd2, 8'd6, 8'd10});
        run_single("mandel_in",  1'b0, 8'd16, 16'h0000, 18, 24'd0);
        run_single("julia",      1'b1, 8'd16, 16'h0180, 4, {8'd1, 8'd3, 8'd5});
        run_single("maxiter1",   1'b0, 8'd1,  16'h0200, 3, 24'd0);

        bp_mode = 1;
        julia_mode = 1'b0; max_iter = 8'd10;
        origin_re = 16'hFE00; origin_im = 16'hFF00; step_re = 16'h00C0; step_im = 16'h00C0;
        julia_re = 16'hFF34; julia_im = 16'h0040; g_mul = 8'd7; b_mul = 8'd11;
        @(posedge clk);
        #1;
        base = hs_cnt;
        push_frame();
        enable = 1'b1;
        wait_hs("frame_a_mid", base + 5);
        max_iter = 8'd5;
        julia_mode = 1'b1;
        push_frame();
        wait_hs("frame_b_mid", base + 16);
        enable = 1'b0;
        wait_drain("raster");
        check("raster_pixels", 32'(hs_cnt - base), 32'(2 * XS * YS));
        base = hs_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("stopped_valid", 32'(valid), 32'd0);
        check("stopped_hs", 32'(hs_cnt), 32'(base));

        bp_mode = 2;
        julia_mode = 1'b0; max_iter = 8'd16; origin_re = 16'h0200; origin_im = '0;
        step_re = '0; step_im = '0; g_mul = 8'd3; b_mul = 8'd5;
        @(posedge clk);
        #1;
        push_frame();
        enable = 1'b1;
        wait_valid("rst_mid", n);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_rgb", 32'({r, g, b}), 32'd0);
        check("rst_mid_flags", 32'({sof, eol}), 32'd0);
        sb.delete();
        bp_mode = 0;
        push_frame();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_valid("restart", n);
        check("restart_sof", 32'(sof), 32'd1);
        check("restart_rgb", 32'({r, g, b}), 32'({8'd2, 8'd6, 8'd10}));
        enable = 1'b0;
        wait_drain("restart");

        check("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
